riscv_test_monitor: RTL and testbench

//  Synthesizable end-of-test monitor for riscv-tests runs on Core. Replaces ad-hoc PC/gp polling in benches.

---
 rtl/riscv_test_pkg.sv | 20 ++
 rtl/riscv_test_monitor_if.sv | 28 ++
 rtl/riscv_test_monitor_sat_counter.sv | 21 ++
 rtl/riscv_test_monitor.sv | 111 +++++++++++
 tb/tb_riscv_test_monitor.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_test_pkg.sv
// Shared constants and enums for the riscv-tests end-of-test monitor.
package riscv_test_pkg;

   localparam int unsigned MODE_PC     = 0;
   localparam int unsigned MODE_TOHOST = 1;
   localparam int unsigned MODE_BOTH   = 2;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      V_NONE    = 2'd0,
      V_PASS    = 2'd1,
      V_FAIL    = 2'd2,
      V_TIMEOUT = 2'd3
   } verdict_e;

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Core-side observation signals and verdict outputs of the test monitor.
interface riscv_test_monitor_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   logic              enable;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   gp;
   logic              st_valid;
   logic [XLEN-1:0]   st_addr;
   logic [XLEN-1:0]   st_data;
   logic              done;
   logic              pass;
   logic              fail;
   logic              timeout;
   logic [XLEN-2:0]   fail_testnum;
   logic [CNT_W-1:0]  cycle_count;

   modport master (
      output enable, pc, gp, st_valid, st_addr, st_data,
      input  done, pass, fail, timeout, fail_testnum, cycle_count
   );

   modport slave (
      input  enable, pc, gp, st_valid, st_addr, st_data,
      output done, pass, fail, timeout, fail_testnum, cycle_count
   );
endinterface

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: PC-halt and/or tohost watch, sticky pass/fail/timeout verdict.
module riscv_test_monitor
   import riscv_test_pkg::*;
#(
   parameter int unsigned     XLEN           = 32,
   parameter int unsigned     MODE           = MODE_BOTH,
   parameter logic [XLEN-1:0] HALT_PC        = XLEN'('h44),
   parameter int unsigned     STABLE_CYCLES  = 2,
   parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'('h1000),
   parameter int unsigned     TIMEOUT_CYCLES = 5000,
   parameter int unsigned     CNT_W          = 32
) (
   input logic                 clk,
   input logic                 rst,
   riscv_test_monitor_if.slave mon
);
   localparam int unsigned SC_W = $clog2(STABLE_CYCLES + 1);

   state_e           state_q, state_d;
   verdict_e         verdict_d;
   logic [XLEN-2:0]  testnum_d;
   logic             run_en;
   logic             pc_match;
   logic             pc_evt;
   logic             th_evt;
   logic             tmo_evt;
   logic [SC_W-1:0]  stable_cnt;
   logic [CNT_W-1:0] cycle_cnt;
   logic             done_q, pass_q, fail_q, timeout_q;
   logic [XLEN-2:0]  testnum_q;

   assign run_en   = (state_q == ST_RUN) && mon.enable;
   assign pc_match = (mon.pc == HALT_PC);
   assign pc_evt   = (MODE != MODE_TOHOST) && pc_match &&
                     (stable_cnt >= SC_W'(STABLE_CYCLES - 1));
   assign th_evt   = (MODE != MODE_PC) && mon.st_valid &&
                     (mon.st_addr == TOHOST_ADDR) && mon.st_data[0];
   assign tmo_evt  = (TIMEOUT_CYCLES != 0) &&
                     (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Consecutive HALT_PC cycles seen before the current one.
   sat_counter #(.W(SC_W)) u_stable_cnt (
      .clk   (clk),
      .clr_i (rst || (run_en && !pc_match)),
      .en_i  (run_en && pc_match),
      .cnt_o (stable_cnt)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (run_en),
      .cnt_o (cycle_cnt)
   );

   // Event priority: tohost store, then PC halt, then timeout.
   always_comb begin
      state_d   = state_q;
      verdict_d = V_NONE;
      testnum_d = '0;
      if (run_en) begin
         if (th_evt) begin
            if (mon.st_data == XLEN'(1)) begin
               verdict_d = V_PASS;
            end else begin
               verdict_d = V_FAIL;
               testnum_d = mon.st_data[XLEN-1:1];
            end
         end else if (pc_evt) begin
            if (mon.gp == XLEN'(1)) begin
               verdict_d = V_PASS;
            end else begin
               verdict_d = V_FAIL;
               testnum_d = mon.gp[XLEN-1:1];
            end
         end else if (tmo_evt) begin
            verdict_d = V_TIMEOUT;
         end
         if (verdict_d != V_NONE) begin
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         testnum_q <= '0;
      end else begin
         state_q <= state_d;
         if (verdict_d != V_NONE) begin
            done_q    <= 1'b1;
            pass_q    <= (verdict_d == V_PASS);
            fail_q    <= (verdict_d == V_FAIL);
            timeout_q <= (verdict_d == V_TIMEOUT);
            testnum_q <= testnum_d;
         end
      end
   end

   assign mon.done         = done_q;
   assign mon.pass         = pass_q;
   assign mon.fail         = fail_q;
   assign mon.timeout      = timeout_q;
   assign mon.fail_testnum = testnum_q;
   assign mon.cycle_count  = cycle_cnt;
endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: two configurations against a cycle-level behavioural model.
module tb_riscv_test_monitor;
   logic        clk = 1'b0;
   logic        rst, en, sv;
   logic [31:0] pc, gp, sa, sd;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      bit          done, pass, fail, tmo;
      logic [30:0] num;
      logic [31:0] cnt;
      int          streak;
   } mdl_t;

   mdl_t ma, mb;

   always #5 clk = ~clk;

   riscv_test_monitor_if #(.XLEN(32), .CNT_W(32)) ifa ();
   riscv_test_monitor_if #(.XLEN(32), .CNT_W(32)) ifb ();

   assign ifa.enable = en;  assign ifb.enable = en;
   assign ifa.pc = pc;      assign ifb.pc = pc;
   assign ifa.gp = gp;      assign ifb.gp = gp;
   assign ifa.st_valid = sv; assign ifb.st_valid = sv;
   assign ifa.st_addr = sa; assign ifb.st_addr = sa;
   assign ifa.st_data = sd; assign ifb.st_data = sd;

   // A: both watches, 2-cycle hold, timeout 10. B: PC only, 3-cycle hold, no timeout.
   riscv_test_monitor #(.MODE(2), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(10)) dut_a (
      .clk(clk), .rst(rst), .mon(ifa));
   riscv_test_monitor #(.MODE(0), .STABLE_CYCLES(3), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .mon(ifb));

   logic [66:0] obs_a, obs_b;
   assign obs_a = {ifa.done, ifa.pass, ifa.fail, ifa.timeout, ifa.fail_testnum, ifa.cycle_count};
   assign obs_b = {ifb.done, ifb.pass, ifb.fail, ifb.timeout, ifb.fail_testnum, ifb.cycle_count};

   function automatic logic [66:0] pk(mdl_t m);
      return {m.done, m.pass, m.fail, m.tmo, m.num, m.cnt};
   endfunction

   // One clock of the test-end rules for a monitor with the given configuration.
   function automatic mdl_t mstep(mdl_t m, int mode, int stab, int tlim, bit r, bit e,
                                  logic [31:0] pcv, logic [31:0] gpv, bit svv,
                                  logic [31:0] sav, logic [31:0] sdv);
      mdl_t        n;
      bit          th, pe, to;
      logic [31:0] code;
      n = m;
      if (r) begin
         n = '{0, 0, 0, 0, 31'd0, 32'd0, 0};
         return n;
      end
      if (m.done || !e) return m;
      n.cnt    = (m.cnt == 32'hFFFF_FFFF) ? m.cnt : m.cnt + 32'd1;
      n.streak = (pcv == 32'h44) ? m.streak + 1 : 0;
      th = (mode != 0) && svv && (sav == 32'h1000) && sdv[0];
      pe = (mode != 1) && (pcv == 32'h44) && (n.streak >= stab);
      to = (tlim != 0) && (m.cnt == 32'(tlim - 1));
      if (th || pe) begin
         code   = th ? sdv : gpv;
         n.done = 1;
         if (code == 32'd1) n.pass = 1;
         else begin
            n.fail = 1;
            n.num  = code[31:1];
         end
      end else if (to) begin
         n.done = 1;
         n.tmo  = 1;
      end
      return n;
   endfunction

   task automatic tick();
      ma = mstep(ma, 2, 2, 10, rst, en, pc, gp, sv, sa, sd);
      mb = mstep(mb, 0, 3, 0, rst, en, pc, gp, sv, sa, sd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b1; pc = 32'h0; gp = 32'h0; sv = 1'b0; sa = 32'h0; sd = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; pc = 32'h44; gp = 32'h1; sv = 1'b1; sa = 32'h1000; sd = 32'h7;
      tick();
      tick();
      rst = 1'b0;
      idle_inputs();
      checks++;
      if (obs_a !== 67'd0) begin errors++; $display("FAIL reset_a: got %h expected 0", obs_a); end
      checks++;
      if (obs_b !== 67'd0) begin errors++; $display("FAIL reset_b: got %h expected 0", obs_b); end
   endtask

   task automatic test_pc_pass();
      logic [66:0] exp;
      do_reset();
      repeat (3) tick();
      pc = 32'h44; gp = 32'h1;
      tick();
      checks++;
      if (ifa.done !== 1'b0) begin errors++; $display("FAIL pass_early_a: done got %b expected 0", ifa.done); end
      tick();
      exp = {4'b1100, 31'd0, 32'd5};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL pass_a: got %h expected %h", obs_a, exp); end
      tick();
      exp = {4'b1100, 31'd0, 32'd6};
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL pass_b: got %h expected %h", obs_b, exp); end
      pc = 32'h0;
      repeat (3) tick();
      exp = {4'b1100, 31'd0, 32'd5};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL pass_frozen_a: got %h expected %h", obs_a, exp); end
   endtask

   task automatic test_pc_fail();
      logic [66:0] exp;
      do_reset();
      pc = 32'h44; gp = 32'h0000_000B;
      tick();
      tick();
      exp = {4'b1010, 31'd5, 32'd2};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL fail_a: got %h expected %h", obs_a, exp); end
      tick();
      exp = {4'b1010, 31'd5, 32'd3};
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL fail_b: got %h expected %h", obs_b, exp); end
   endtask

   task automatic test_pc_glitch();
      logic [66:0] exp;
      do_reset();
      pc = 32'h44; gp = 32'h1;
      tick();
      pc = 32'h48;
      tick();
      pc = 32'h44;
      tick();
      checks++;
      if (ifa.done !== 1'b0) begin errors++; $display("FAIL glitch_a: done got %b expected 0", ifa.done); end
      tick();
      exp = {4'b1100, 31'd0, 32'd4};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL glitch_hold_a: got %h expected %h", obs_a, exp); end
      checks++;
      if (ifb.done !== 1'b0) begin errors++; $display("FAIL glitch_b: done got %b expected 0", ifb.done); end
      tick();
      exp = {4'b1100, 31'd0, 32'd5};
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL glitch_hold_b: got %h expected %h", obs_b, exp); end
   endtask

   task automatic test_both();
      logic [66:0] exp;
      do_reset();
      sv = 1'b1; sa = 32'h1000; sd = 32'h2;
      tick();
      sv = 1'b0;
      pc = 32'h44; gp = 32'h1;
      tick();
      checks++;
      if (ifa.done !== 1'b0) begin errors++; $display("FAIL even_store_a: done got %b expected 0", ifa.done); end
      sv = 1'b1; sd = 32'h7;
      tick();
      sv = 1'b0;
      exp = {4'b1010, 31'd3, 32'd3};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL tohost_prio_a: got %h expected %h", obs_a, exp); end
      checks++;
      if (ifb.done !== 1'b0) begin errors++; $display("FAIL tohost_ignored_b: done got %b expected 0", ifb.done); end
   endtask

   task automatic test_timeout();
      logic [66:0] exp;
      do_reset();
      repeat (9) tick();
      exp = {4'b0000, 31'd0, 32'd9};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL tmo_early_a: got %h expected %h", obs_a, exp); end
      tick();
      exp = {4'b1001, 31'd0, 32'd10};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL tmo_a: got %h expected %h", obs_a, exp); end
      exp = {4'b0000, 31'd0, 32'd10};
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL no_tmo_b: got %h expected %h", obs_b, exp); end
      do_reset();
      repeat (5) tick();
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      repeat (4) tick();
      exp = {4'b0000, 31'd0, 32'd9};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL tmo_en_early_a: got %h expected %h", obs_a, exp); end
      tick();
      exp = {4'b1001, 31'd0, 32'd10};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL tmo_en_a: got %h expected %h", obs_a, exp); end
   endtask

   task automatic test_rst_done();
      logic [66:0] exp;
      pc = 32'h44; gp = 32'h1; en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en = 1'b1;
      checks++;
      if (obs_a !== 67'd0) begin errors++; $display("FAIL rst_done_a: got %h expected 0", obs_a); end
      checks++;
      if (obs_b !== 67'd0) begin errors++; $display("FAIL rst_done_b: got %h expected 0", obs_b); end
      tick();
      tick();
      exp = {4'b1100, 31'd0, 32'd2};
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL rerun_a: got %h expected %h", obs_a, exp); end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         en  = ($urandom_range(0, 7) != 0);
         r   = int'($urandom_range(0, 3));
         pc  = (r < 2) ? 32'h44 : (r == 2) ? 32'h48 : $urandom;
         gp  = $urandom_range(0, 1) ? 32'h1 : 32'($urandom_range(0, 63));
         sv  = ($urandom_range(0, 5) == 0);
         sa  = $urandom_range(0, 1) ? 32'h1000 : $urandom;
         sd  = 32'($urandom_range(0, 15));
         tick();
         checks++;
         if (obs_a !== pk(ma)) begin
            errors++; $display("FAIL rand_a cyc %0d: got %h expected %h", i, obs_a, pk(ma));
         end
         checks++;
         if (obs_b !== pk(mb)) begin
            errors++; $display("FAIL rand_b cyc %0d: got %h expected %h", i, obs_b, pk(mb));
         end
         checks++;
         if ($countones({ifa.pass, ifa.fail, ifa.timeout}) != (ma.done ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_onehot_a cyc %0d: got %b%b%b expected %0d set", i,
                     ifa.pass, ifa.fail, ifa.timeout, ma.done ? 1 : 0);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      ma = '{0, 0, 0, 0, 31'd0, 32'd0, 0};
      mb = '{0, 0, 0, 0, 31'd0, 32'd0, 0};
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_pc_pass();
      test_pc_fail();
      test_pc_glitch();
      test_both();
      test_timeout();
      test_rst_done();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
